// File: rtl/mag_comp_iter_if.sv
// Operand/result bundle for the iterative magnitude comparator.
// master = requester (drives operands and start), slave = comparator.
interface mag_comp_iter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             valid;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, valid, gt, eq, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, valid, gt, eq, lt
  );
endinterface

// File: rtl/mag_comp_iter.sv
// Iterative magnitude comparator: walks two WIDTH-bit operands MSB first,
// DIGIT bits per cycle, and reports gt/eq/lt under a start/busy/done
// handshake. Signed compares flip both sign bits at latch time so that the
// digit walk is always an unsigned compare.
module mag_comp_iter #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  mag_comp_iter_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  // Latched operands, shifted left one digit per RUN cycle so the digit
  // under examination always sits in the top DIGIT bits.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Running decision; both low means "equal so far".
  logic             run_gt_reg;
  logic             run_lt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             valid_reg;
  logic             gt_reg;
  logic             eq_reg;
  logic             lt_reg;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             undecided;
  logic             step_gt;
  logic             step_lt;
  logic             last_step;
  logic             finish;

  // Operand conditioning at latch time: inverting the sign bit of both
  // operands maps two's-complement order onto unsigned order.
  always_comb begin
    a_in = bus.a;
    b_in = bus.b;
    if (bus.signed_mode) begin
      a_in[WIDTH-1] = ~bus.a[WIDTH-1];
      b_in[WIDTH-1] = ~bus.b[WIDTH-1];
    end
  end

  // Current digit compare and finish decision for this RUN cycle.
  always_comb begin
    a_dig     = a_reg[WIDTH-1 -: DIGIT];
    b_dig     = b_reg[WIDTH-1 -: DIGIT];
    undecided = !run_gt_reg && !run_lt_reg;
    step_gt   = run_gt_reg || (undecided && (a_dig > b_dig));
    step_lt   = run_lt_reg || (undecided && (a_dig < b_dig));
    last_step = (idx_reg == IDX_W'(STEPS - 1));
    finish    = last_step ||
                ((EARLY_EXIT != 0) && undecided && (a_dig != b_dig));
  end

  // Handshake FSM and digit walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      run_gt_reg <= 1'b0;
      run_lt_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      gt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg      <= a_in;
            b_reg      <= b_in;
            idx_reg    <= '0;
            run_gt_reg <= 1'b0;
            run_lt_reg <= 1'b0;
            valid_reg  <= 1'b0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        default: begin
          run_gt_reg <= step_gt;
          run_lt_reg <= step_lt;
          a_reg      <= a_reg << DIGIT;
          b_reg      <= b_reg << DIGIT;
          idx_reg    <= idx_reg + IDX_W'(1);
          if (finish) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            valid_reg <= 1'b1;
            gt_reg    <= step_gt;
            lt_reg    <= step_lt;
            eq_reg    <= !step_gt && !step_lt;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.valid = valid_reg;
  assign bus.gt    = gt_reg;
  assign bus.eq    = eq_reg;
  assign bus.lt    = lt_reg;

endmodule

// File: tb/tb_mag_comp_iter.sv
// Bench for mag_comp_iter: four instances (8/2 fixed, 8/2 early exit,
// 2/1 fixed, 2/1 early exit) share one clock and reset. Expected results
// come from an integer-arithmetic model of the compare and its latency.
module tb_mag_comp_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mag_comp_iter_if #(.WIDTH(8)) if0 ();
  mag_comp_iter_if #(.WIDTH(8)) if1 ();
  mag_comp_iter_if #(.WIDTH(2)) if2 ();
  mag_comp_iter_if #(.WIDTH(2)) if3 ();

  mag_comp_iter #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mag_comp_iter #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mag_comp_iter #(.WIDTH(2), .DIGIT(1), .EARLY_EXIT(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mag_comp_iter #(.WIDTH(2), .DIGIT(1), .EARLY_EXIT(1)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [3:0] start_v = '0;
  logic [3:0] sm_v    = '0;
  logic [7:0] a_v [4];
  logic [7:0] b_v [4];
  logic [3:0] busy_v, done_v, valid_v, gt_v, eq_v, lt_v;

  assign if0.start = start_v[0]; assign if0.signed_mode = sm_v[0];
  assign if0.a = a_v[0];         assign if0.b = b_v[0];
  assign if1.start = start_v[1]; assign if1.signed_mode = sm_v[1];
  assign if1.a = a_v[1];         assign if1.b = b_v[1];
  assign if2.start = start_v[2]; assign if2.signed_mode = sm_v[2];
  assign if2.a = a_v[2][1:0];    assign if2.b = b_v[2][1:0];
  assign if3.start = start_v[3]; assign if3.signed_mode = sm_v[3];
  assign if3.a = a_v[3][1:0];    assign if3.b = b_v[3][1:0];

  assign busy_v  = {if3.busy,  if2.busy,  if1.busy,  if0.busy};
  assign done_v  = {if3.done,  if2.done,  if1.done,  if0.done};
  assign valid_v = {if3.valid, if2.valid, if1.valid, if0.valid};
  assign gt_v    = {if3.gt,    if2.gt,    if1.gt,    if0.gt};
  assign eq_v    = {if3.eq,    if2.eq,    if1.eq,    if0.eq};
  assign lt_v    = {if3.lt,    if2.lt,    if1.lt,    if0.lt};

  int n_cmp = 0;
  int n_err = 0;

  // Reference: integer compare plus latency from the first differing digit.
  function automatic void ref_cmp(input int sel, input logic [7:0] a, input logic [7:0] b,
                                  input logic sm, output logic [3:0] flags, output int lat);
    int w, d, ee, va, vb, steps, mask, sh;
    w  = (sel < 2) ? 8 : 2;
    d  = (sel < 2) ? 2 : 1;
    ee = sel % 2;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sm && va >= (1 << (w - 1))) va = va - (1 << w);
    if (sm && vb >= (1 << (w - 1))) vb = vb - (1 << w);
    flags = {1'b1, va > vb, va == vb, va < vb};
    steps = w / d;
    mask  = (1 << d) - 1;
    lat   = steps;
    if (ee != 0) begin
      for (int i = 0; i < steps; i++) begin
        sh = w - (i + 1) * d;
        if (((int'(a) >> sh) & mask) != ((int'(b) >> sh) & mask)) begin
          lat = i + 1;
          break;
        end
      end
    end
  endfunction

  // Issue one start (caller sits just after a rising edge) and collect
  // the handshake state after the accept edge, latency and result flags.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output int lat, output logic [3:0] flags, output logic [2:0] acc);
    start_v[sel] = 1'b1;
    a_v[sel] = a;
    b_v[sel] = b;
    sm_v[sel] = sm;
    @(posedge clk); #1;
    acc = {busy_v[sel], done_v[sel], valid_v[sel]};
    start_v[sel] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[sel]) begin
        lat = c;
        break;
      end
    end
    flags = {valid_v[sel], gt_v[sel], eq_v[sel], lt_v[sel]};
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    start_v = 4'hF;
    for (int i = 0; i < 4; i++) begin a_v[i] = 8'h81; b_v[i] = 8'h02; end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      obs = {busy_v[0], done_v[0], valid_v[0], gt_v[0], eq_v[0], lt_v[0]};
      n_cmp++;
      if (obs !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%b want=000000", c, obs);
      end
    end
    start_v = 4'h0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      obs = {busy_v[0], done_v[0], valid_v[0], gt_v[0], eq_v[0], lt_v[0]};
      n_cmp++;
      if (obs !== 6'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b want=000000", c, obs);
      end
    end
    $display("reset: checked hold and idle after release");
  endtask

  // Directed table followed by random operands for one instance.
  task automatic test_compare(input int sel, input int n_rand);
    logic [7:0] ta [6] = '{8'hA5, 8'h12, 8'h3C, 8'h80, 8'h80, 8'hC0};
    logic [7:0] tb [6] = '{8'h5A, 8'h13, 8'h3C, 8'h01, 8'h01, 8'h40};
    logic       ts [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] a, b;
    logic sm;
    logic [3:0] flags, eflags;
    logic [2:0] acc;
    int lat, elat;
    for (int i = 0; i < 6 + n_rand; i++) begin
      if (i < 6) begin
        a = ta[i]; b = tb[i]; sm = ts[i];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 2) == 0) ? (a ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) b = a;
        sm = 1'($urandom_range(0, 1));
      end
      ref_cmp(sel, a, b, sm, eflags, elat);
      run_op(sel, a, b, sm, lat, flags, acc);
      n_cmp++;
      if (acc !== 3'b100) begin
        n_err++;
        $display("FAIL accept dut%0d a=%h b=%h got busy/done/valid=%b want=100", sel, a, b, acc);
      end
      n_cmp++;
      if (lat !== elat) begin
        n_err++;
        $display("FAIL latency dut%0d a=%h b=%h sm=%0d got=%0d want=%0d", sel, a, b, sm, lat, elat);
      end
      n_cmp++;
      if (flags !== eflags) begin
        n_err++;
        $display("FAIL result dut%0d a=%h b=%h sm=%0d got v/gt/eq/lt=%b want=%b", sel, a, b, sm, flags, eflags);
      end
      $display("compare dut%0d a=%h b=%h sm=%0d lat=%0d flags=%b", sel, a, b, sm, lat, flags);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [3:0] flags;
    start_v[0] = 1'b1; a_v[0] = 8'h10; b_v[0] = 8'h20; sm_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h00;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = -1;
    for (int c = 3; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin lat = c; break; end
    end
    flags = {valid_v[0], gt_v[0], eq_v[0], lt_v[0]};
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL busy_ignore_latency got=%0d want=4", lat);
    end
    n_cmp++;
    if (flags !== 4'b1001) begin
      n_err++;
      $display("FAIL busy_ignore_result got=%b want=1001", flags);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (busy_v[0] !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ignore_queued cyc=%0d got busy=%b want=0", c, busy_v[0]);
      end
    end
    $display("busy_ignore: lat=%0d flags=%b", lat, flags);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [3:0] flags;
    logic [2:0] acc;
    run_op(0, 8'h44, 8'h43, 1'b0, lat, flags, acc);
    n_cmp++;
    if (flags !== 4'b1100 || lat !== 4) begin
      n_err++;
      $display("FAIL b2b_first got flags=%b lat=%0d want=1100 lat=4", flags, lat);
    end
    // Still in the done cycle: start again immediately.
    run_op(0, 8'hFE, 8'h02, 1'b1, lat, flags, acc);
    n_cmp++;
    if (acc !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_accept got busy/done/valid=%b want=100", acc);
    end
    n_cmp++;
    if (flags !== 4'b1001 || lat !== 4) begin
      n_err++;
      $display("FAIL b2b_second got flags=%b lat=%0d want=1001 lat=4", flags, lat);
    end
    $display("back_to_back: second lat=%0d flags=%b", lat, flags);
  endtask

  task automatic test_abort();
    logic [5:0] obs;
    int seen;
    start_v[0] = 1'b1; a_v[0] = 8'h99; b_v[0] = 8'h11; sm_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs = {busy_v[0], done_v[0], valid_v[0], gt_v[0], eq_v[0], lt_v[0]};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_err++;
      $display("FAIL abort_outputs got=%b want=000000", obs);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_done got=%0d active cycles want=0", seen);
    end
    $display("abort: outputs=%b active_after=%0d", obs, seen);
  endtask

  task automatic test_sweep();
    int lat, elat;
    logic [3:0] flags, eflags;
    logic [2:0] acc;
    for (int sel = 2; sel < 4; sel++) begin
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < 16; p++) begin
          ref_cmp(sel, 8'(p >> 2), 8'(p & 3), 1'(m), eflags, elat);
          run_op(sel, 8'(p >> 2), 8'(p & 3), 1'(m), lat, flags, acc);
          n_cmp++;
          if (flags !== eflags || lat !== elat || lat > 2 || acc !== 3'b100) begin
            n_err++;
            $display("FAIL sweep dut%0d a=%0d b=%0d sm=%0d got flags=%b lat=%0d acc=%b want flags=%b lat=%0d acc=100",
                     sel, p >> 2, p & 3, m, flags, lat, acc, eflags, elat);
          end
          $display("sweep dut%0d a=%0d b=%0d sm=%0d lat=%0d flags=%b", sel, p >> 2, p & 3, m, lat, flags);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin a_v[i] = '0; b_v[i] = '0; end
    test_reset();
    test_compare(0, 24);
    test_compare(1, 24);
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mag_comp_iter.md
Name: mag_comp_iter

Overview:
- Parametrised, iterative magnitude comparator; successor to the 2-bit combinational comparator on the project wrapper.
- Compares two WIDTH-bit operands DIGIT bits per cycle, MSB first, under a start/busy/done handshake.
- Supports unsigned or two's-complement signed mode, with optional early exit on the first differing digit.
- Sits behind the top-level wrapper: operands come from ui_in/uio_in registers, and gt/eq/lt/valid drive uo_out.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥1.
- DIGIT, 2: bits examined per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT must equal 0.
- EARLY_EXIT, 0: 1 = finish on the first differing digit; 0 = fixed latency.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- start, input, 1: request a comparison; sampled only in IDLE.
- signed_mode, input, 1: 1 = two's-complement compare; latched with the operands.
- a, input, WIDTH: operand A; latched when start is accepted.
- b, input, WIDTH: operand B; latched when start is accepted.
- busy, output, 1: high while a comparison is in progress.
- done, output, 1: one-cycle pulse when the result becomes valid.
- valid, output, 1: high from done until the next accepted start.
- gt, output, 1: A > B; qualified by valid.
- eq, output, 1: A == B; qualified by valid.
- lt, output, 1: A < B; qualified by valid.

Behaviour:
- STEPS = WIDTH/DIGIT. All outputs are registered.
- Reset values: busy=0, done=0, valid=0, gt=eq=lt=0, state=IDLE, internal registers cleared.
- FSM has two states, IDLE and RUN.
- IDLE with start=1 at an edge:
  - latch a, b and signed_mode;
  - digit index = 0 (MSB digit);
  - clear valid, gt, eq, lt;
  - busy=1; go to RUN.
- IDLE with start=0: hold all outputs.
- RUN, each edge: compare digit i (bits WIDTH-1-i·DIGIT down to WIDTH-DIGIT-i·DIGIT) of the latched operands.
  - While the running decision is "equal so far": if the digits differ, record gt or lt from the unsigned compare of the digits.
  - Once decided, later digits do not change the decision.
  - Then i = i+1.
- Signed rule: before comparison, invert bit WIDTH-1 of both latched operands; an unsigned compare of the result equals the signed compare.
- Finish condition: the edge processing digit STEPS-1, or, if EARLY_EXIT=1, the edge on which the first differing digit is seen.
- At the finish edge:
  - busy=0, done=1, valid=1;
  - exactly one of gt/eq/lt=1 (eq when no digit differed);
  - go to IDLE.
- Latency: done is high in the cycle after the Nth RUN edge, where N = STEPS (fixed) or the 1-based index of the first differing digit (early exit).
  - Example, WIDTH=8, DIGIT=2: start sampled at edge 0, done visible after edge 4.
- done is cleared on the following edge. valid, gt, eq and lt hold until the next accepted start.
- start while busy=1: ignored; no queuing; operands are not re-latched.
- start in the cycle where done=1: accepted (state is already IDLE). At that edge done, valid and the result flags clear; busy=1.
- Input changes on a, b or signed_mode during RUN have no effect.
- rst=1 at any edge, including mid-RUN: return to the reset values; no done pulse is produced for the aborted operation.
- rst has priority over start.
- Invariant: gt+eq+lt ≤ 1 always; gt+eq+lt = 1 exactly when valid=1.

Test Plan:
1. Reset (WIDTH=8, DIGIT=2):
   - Hold rst=1 for 2 cycles with start=1 → busy=done=valid=gt=eq=lt=0 throughout.
   - Release rst → nothing starts until start is sampled in IDLE.
2. Fixed latency (EARLY_EXIT=0), unsigned:
   - a=0xA5, b=0x5A, start pulse → busy high 4 cycles; done pulse 4 cycles after start; gt=1, valid=1.
   - a=0x12, b=0x13 → lt=1 after 4 cycles.
3. Equality and signed mode:
   - a=b=0x3C → eq=1 after 4 cycles. With EARLY_EXIT=1, still 4 cycles, eq=1.
   - a=0x80, b=0x01, signed_mode=1 → lt=1 (-128 < 1).
   - Same operands, signed_mode=0 → gt=1.
4. Early exit (EARLY_EXIT=1):
   - a=0xC0, b=0x40 → done 1 cycle after start, gt=1.
   - a=0x12, b=0x13 → done after 4 cycles, lt=1.
   - a=0x1F, b=0x2F → done after 2 cycles, lt=1.
5. Handshake and abort:
   - start re-asserted with new operands while busy → ignored; result is for the first operands.
   - Back-to-back start in the done cycle → accepted; valid drops at that edge.
   - rst asserted 2 cycles into RUN → no done pulse; all outputs 0.
6. Exhaustive sweep (WIDTH=2, DIGIT=1, both EARLY_EXIT values, both modes):
   - All 16 (A,B) pairs → exactly one of gt/eq/lt set, matching the integer compare.
   - Latency ≤ 2 cycles.
